div_share_ctrl: RTL and testbench
=================================

# div_share_ctrl

Sequential divider controller that shares one iterative restoring divider among NREQ requesters. Arbitrates requests round-robin, accepts one operand pair at a time, computes quotient and remainder one bit per cycle, and returns the result tagged with the requester index. Sits between client blocks and the integer-division datapath. It supersedes direct use of the combinational 4-bit divider wherever several clients need division.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- NREQ, 2, number of requesters (≥2); IDW = max(1, $clog2(NREQ))

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_dividend  in  NREQ×WIDTH  dividend per requester
- req_divisor  in  NREQ×WIDTH  divisor per requester
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumer ready
- rsp_id  out  IDW  index of requester that owns the result
- rsp_quotient  out  WIDTH  quotient
- rsp_remainder  out  WIDTH  remainder
- rsp_div0  out  1  divisor was zero
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - Grant = first i with req_valid[i], searching from rr_ptr upward, wrapping modulo NREQ.
  - req_ready[grant] = 1, combinationally, in IDLE only; all other req_ready bits are 0.
  - Handshake occurs when req_valid[grant] && req_ready[grant].
  - On handshake: latch operands and id.
  - If divisor == 0: go to DONE.
  - Otherwise: initialise partial remainder (WIDTH+1 bits) = 0, quotient register = dividend, step counter = 0; go to CALC.
- CALC, one restoring step per cycle:
  - rem = {rem[WIDTH-1:0], q[WIDTH-1]}; q = q << 1.
  - If rem ≥ {0, divisor}: rem = rem − divisor, q[0] = 1.
  - After WIDTH steps (counter == WIDTH−1), go to DONE.
- DONE:
  - rsp_valid = 1.
  - Normal result: quotient = q, remainder = rem[WIDTH-1:0], div0 = 0.
  - Divide by zero: quotient = all ones, remainder = dividend, div0 = 1.
  - On rsp_valid && rsp_ready: go to IDLE, rr_ptr = (id + 1) mod NREQ.
- Arithmetic is unsigned. Invariant for divisor ≠ 0: quotient × divisor + remainder == dividend, and remainder < divisor.
- Requests from unselected requesters are not dropped. They wait with req_ready low and must hold valid and data stable, per standard valid/ready rules.

## Timing
- Reset values: state = IDLE, rr_ptr = 0, counter = 0, all data registers = 0.
- Outputs under reset: req_ready = 0 while rst_n is low; rsp_valid = 0, rsp_id = 0, rsp_quotient = 0, rsp_remainder = 0, rsp_div0 = 0, busy = 0.
- Latency, handshake at edge T:
  - Normal: rsp_valid rises after edge T+WIDTH (WIDTH CALC cycles, then DONE).
  - Divisor zero: rsp_valid rises after edge T+1.
- Backpressure: while rsp_valid && !rsp_ready, all rsp_* outputs hold stable and no new request is accepted.
- Throughput: one result per WIDTH+2 cycles at best. This includes the IDLE grant cycle, with no accept in the same cycle as the rsp handshake.
- Simultaneous requests resolve by rr_ptr order. A requester that keeps req_valid high is served within NREQ transactions.
- Reset mid-operation, in any state: asynchronously returns to the reset values. The in-flight transaction is lost and no response is emitted.
- Registered outputs: rsp_*, busy. Combinational output: req_ready, from state, rr_ptr and req_valid only.

## Structure
- Package div_pkg:
  - state enum type div_state_t {IDLE, CALC, DONE}
  - DIV0_QUOT constant (all ones)
  - A helper function for round-robin next-index computation.
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: rem, q, divisor. Outputs: rem_next, q_next. Parameterised by WIDTH.
  - Instantiated once inside div_share_ctrl.

## Test plan
- Single request, WIDTH=4: req0 8/2 -> rsp_valid at T+4, id 0, q 4, r 0, div0 0.
- Simultaneous req0 15/4 and req1 12/5 after reset:
  - req0 is served first: q 3, r 3.
  - req1 is then served: q 2, r 2.
  - Order is unchanged with both held valid.
- Fairness: both requesters continuously valid for 6 transactions -> grants alternate 0,1,0,1,0,1.
- Divide by zero: req1 5/0 -> rsp_valid at T+1, id 1, q 15, r 5, div0 1.
- Backpressure: hold rsp_ready low for 3 cycles on result 7/2 -> q 3, r 1 stable throughout, req_ready stays 0, release resumes normally.
- Reset mid-CALC, plus an exhaustive sweep:
  - Assert rst_n low during step 2 -> all outputs go to reset values immediately. The next request, 9/3, returns q 3, r 0.
  - Sweep all 256 operand pairs -> invariant holds for each.

Source files
------------

// File: rtl/div_share_ctrl_pkg.sv
// Shared types and helpers for the shared iterative divider controller.
// Contents: FSM state enum, divide-by-zero quotient constant, round-robin index helper.
// No logic of its own; imported by the controller.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    // All-ones quotient reported on divide-by-zero; users slice the low WIDTH bits.
    localparam logic [63:0] DIV0_QUOT = '1;

    // Next requester index after idx, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/div_share_ctrl_if.sv
// Request/response bundle between NREQ division clients and the shared divider.
// Ports: req_valid/req_ready/req_dividend/req_divisor per requester; rsp_* result with id; busy.
// Standard valid/ready on both sides; master = client side, slave = divider side.
interface div_share_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 2
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0][WIDTH-1:0] req_dividend;
    logic [NREQ-1:0][WIDTH-1:0] req_divisor;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [IDW-1:0]             rsp_id;
    logic [WIDTH-1:0]           rsp_quotient;
    logic [WIDTH-1:0]           rsp_remainder;
    logic                       rsp_div0;
    logic                       busy;

    modport master (
        output req_valid, req_dividend, req_divisor, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_div0, busy
    );

    modport slave (
        input  req_valid, req_dividend, req_divisor, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_div0, busy
    );
endinterface

// File: rtl/div_share_ctrl_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
// Ports: rem_i/q_i/divisor_i in, rem_o/q_o out. Purely combinational, zero latency.
// No handshake; the controller decides when to register the result.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] q_o
);
    // The shifted partial remainder needs WIDTH+1 bits; after the conditional
    // subtract it is always below the divisor, so WIDTH bits suffice to store it.
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] dvs_ext;
    logic           fits;

    assign rem_sh  = {rem_i, q_i[WIDTH-1]};
    assign dvs_ext = {1'b0, divisor_i};
    assign fits    = (rem_sh >= dvs_ext);

    always_comb begin
        rem_o = rem_sh[WIDTH-1:0];
        q_o   = {q_i[WIDTH-2:0], 1'b0};
        if (fits) begin
            rem_o = WIDTH'(rem_sh - dvs_ext);
            q_o   = {q_i[WIDTH-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/div_share_ctrl.sv
// Shares one iterative restoring divider among NREQ requesters, round-robin, result tagged by id.
// Ports: clk, rst_n, bus (slave). Latency: WIDTH+1 edges to rsp_valid (2 for divide-by-zero).
// Backpressure: rsp_* hold while rsp_ready is low; no request is accepted until the result drains.
module div_share_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NREQ  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    div_share_ctrl_if.slave   bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(WIDTH);

    div_state_t        state_q;
    logic [IDW-1:0]    rr_ptr_q;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  rem_q;
    logic [WIDTH-1:0]  quo_q;
    logic [WIDTH-1:0]  dvd_q;
    logic [WIDTH-1:0]  dvs_q;
    logic [IDW-1:0]    id_q;
    logic              rsp_valid_q;
    logic [IDW-1:0]    rsp_id_q;
    logic [WIDTH-1:0]  rsp_quo_q;
    logic [WIDTH-1:0]  rsp_rem_q;
    logic              rsp_div0_q;
    logic              busy_q;

    logic [WIDTH-1:0]  rem_d;
    logic [WIDTH-1:0]  quo_d;
    logic [IDW-1:0]    grant;
    logic              grant_vld;
    logic [NREQ-1:0]   req_rdy;

    // Round-robin search starting at rr_ptr_q.
    always_comb begin
        logic [IDW-1:0] idx;
        idx       = rr_ptr_q;
        grant     = '0;
        grant_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_vld && bus.req_valid[idx]) begin
                grant_vld = 1'b1;
                grant     = idx;
            end
            idx = IDW'(rr_next(int'(idx), NREQ));
        end
    end

    // rst_n gating keeps req_ready low while reset is held, even though the
    // state register already sits in IDLE.
    always_comb begin
        req_rdy = '0;
        if (rst_n && state_q == IDLE && grant_vld) begin
            req_rdy[grant] = 1'b1;
        end
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .q_i       (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (rem_d),
        .q_o       (quo_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_quo_q   <= '0;
            rsp_rem_q   <= '0;
            rsp_div0_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        id_q   <= grant;
                        dvd_q  <= bus.req_dividend[grant];
                        dvs_q  <= bus.req_divisor[grant];
                        rem_q  <= '0;
                        quo_q  <= bus.req_dividend[grant];
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        state_q <= (bus.req_divisor[grant] == '0) ? DONE : CALC;
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q     <= DONE;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_quo_q   <= quo_d;
                        rsp_rem_q   <= rem_d;
                        rsp_div0_q  <= 1'b0;
                    end
                end
                DONE: begin
                    if (!rsp_valid_q) begin
                        // Only the divide-by-zero path reaches DONE without a
                        // loaded result; it is published one cycle after entry.
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_quo_q   <= DIV0_QUOT[WIDTH-1:0];
                        rsp_rem_q   <= dvd_q;
                        rsp_div0_q  <= 1'b1;
                    end else if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                        rr_ptr_q    <= IDW'(rr_next(int'(id_q), NREQ));
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready     = req_rdy;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_id        = rsp_id_q;
    assign bus.rsp_quotient  = rsp_quo_q;
    assign bus.rsp_remainder = rsp_rem_q;
    assign bus.rsp_div0      = rsp_div0_q;
    assign bus.busy          = busy_q;
endmodule

// File: tb/tb_div_share_ctrl.sv
// Bench for div_share_ctrl: vector table, scoreboard of expected results, directed corner sequences.
// Latency and hold behaviour are measured against the clock; all inputs change 1ns after posedge.
// Outputs are sampled on the falling edge.
module tb_div_share_ctrl;
    localparam int WIDTH = 4;
    localparam int NREQ  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_share_ctrl_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    div_share_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int id;
        int dvd;
        int dvs;
        int q;
        int r;
        int d0;
    } exp_t;

    typedef struct {
        int id;
        int dvd;
        int dvs;
        int q;
        int r;
        int d0;
        int lat;
    } vec_t;

    exp_t sb[$];
    exp_t rsp_log[$];
    int   grant_log[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Request monitor pushes model results; response monitor pops and compares.
    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        if (rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    e.id  = i;
                    e.dvd = int'(bus.req_dividend[i]);
                    e.dvs = int'(bus.req_divisor[i]);
                    if (e.dvs == 0) begin
                        e.q  = (1 << WIDTH) - 1;
                        e.r  = e.dvd;
                        e.d0 = 1;
                    end else begin
                        e.q  = e.dvd / e.dvs;
                        e.r  = e.dvd % e.dvs;
                        e.d0 = 0;
                    end
                    sb.push_back(e);
                    grant_log.push_back(i);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                got.id  = int'(bus.rsp_id);
                got.q   = int'(bus.rsp_quotient);
                got.r   = int'(bus.rsp_remainder);
                got.d0  = int'(bus.rsp_div0);
                got.dvd = 0;
                got.dvs = 0;
                rsp_log.push_back(got);
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_id", got.id, e.id);
                    chk("sb_quot", got.q, e.q);
                    chk("sb_rem", got.r, e.r);
                    chk("sb_div0", got.d0, e.d0);
                    if (e.d0 == 0) begin
                        chk("invariant", got.q * e.dvs + got.r, e.dvd);
                        chk("rem_lt_div", int'(got.r < e.dvs), 1);
                    end
                end
            end
        end
    end

    task automatic issue(input int id, input int dvd, input int dvs);
        bit done;
        done = 1'b0;
        bus.req_dividend[id] = WIDTH'(dvd);
        bus.req_divisor[id]  = WIDTH'(dvs);
        bus.req_valid[id]    = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (bus.req_ready[id]) done = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.req_valid[id] = 1'b0;
        if (!done) chk("hs_timeout", 0, 1);
    endtask

    // Returns at the falling edge where rsp_valid is first seen; lat counts
    // rising edges since the handshake edge.
    task automatic wait_rsp(output int lat);
        bit ok;
        ok  = 1'b0;
        lat = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        if (!ok) chk("rsp_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, int'(bus.rsp_valid), 0);
        chk({tag, "_rsp_id"}, int'(bus.rsp_id), 0);
        chk({tag, "_rsp_quot"}, int'(bus.rsp_quotient), 0);
        chk({tag, "_rsp_rem"}, int'(bus.rsp_remainder), 0);
        chk({tag, "_rsp_div0"}, int'(bus.rsp_div0), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_req_ready"}, int'(bus.req_ready), 0);
    endtask

    vec_t tbl[9];

    initial begin
        int lat;
        bit hs0, hs1, seen;
        int n0, n1;
        int d0s[3];
        int v0s[3];
        int d1s[3];
        int v1s[3];

        tbl[0] = '{0,  8, 2,  4, 0, 0, 4};
        tbl[1] = '{1,  5, 0, 15, 5, 1, 1};
        tbl[2] = '{0,  7, 2,  3, 1, 0, 4};
        tbl[3] = '{1,  9, 3,  3, 0, 0, 4};
        tbl[4] = '{0, 15, 15, 1, 0, 0, 4};
        tbl[5] = '{1,  0, 7,  0, 0, 0, 4};
        tbl[6] = '{0, 15, 1, 15, 0, 0, 4};
        tbl[7] = '{1,  3, 7,  0, 3, 0, 4};
        tbl[8] = '{0,  0, 0, 15, 0, 1, 1};

        bus.req_valid    = '0;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        bus.rsp_ready    = 1'b1;

        // Reset state, with requests pending to show req_ready is held low.
        bus.req_valid = '1;
        bus.req_dividend[0] = 4'd3;
        bus.req_divisor[0]  = 4'd1;
        #2;
        chk_reset_outputs("reset");
        do_reset();
        chk("post_reset_busy", int'(bus.busy), 0);

        // Table vectors, one requester at a time.
        for (int i = 0; i < 9; i++) begin
            issue(tbl[i].id, tbl[i].dvd, tbl[i].dvs);
            chk("tbl_busy", int'(bus.busy), 1);
            wait_rsp(lat);
            chk("tbl_latency", lat, tbl[i].lat);
            chk("tbl_id", int'(bus.rsp_id), tbl[i].id);
            chk("tbl_quot", int'(bus.rsp_quotient), tbl[i].q);
            chk("tbl_rem", int'(bus.rsp_remainder), tbl[i].r);
            chk("tbl_div0", int'(bus.rsp_div0), tbl[i].d0);
            @(posedge clk);
            #1;
            chk("tbl_rsp_drop", int'(bus.rsp_valid), 0);
            chk("tbl_idle_busy", int'(bus.busy), 0);
        end

        // Simultaneous requests and fairness: both held valid for 3 transactions each.
        do_reset();
        grant_log.delete();
        rsp_log.delete();
        d0s = '{15, 14, 11}; v0s = '{4, 3, 2};
        d1s = '{12, 13, 10}; v1s = '{5, 6, 10};
        n0 = 0; n1 = 0;
        bus.req_dividend[0] = WIDTH'(d0s[0]); bus.req_divisor[0] = WIDTH'(v0s[0]);
        bus.req_dividend[1] = WIDTH'(d1s[0]); bus.req_divisor[1] = WIDTH'(v1s[0]);
        bus.req_valid = 2'b11;
        for (int t = 0; t < 300 && (n0 + n1) < 6; t++) begin
            @(negedge clk);
            hs0 = bus.req_valid[0] && bus.req_ready[0];
            hs1 = bus.req_valid[1] && bus.req_ready[1];
            @(posedge clk);
            #1;
            if (hs0) begin
                n0++;
                if (n0 < 3) begin
                    bus.req_dividend[0] = WIDTH'(d0s[n0]);
                    bus.req_divisor[0]  = WIDTH'(v0s[n0]);
                end else bus.req_valid[0] = 1'b0;
            end
            if (hs1) begin
                n1++;
                if (n1 < 3) begin
                    bus.req_dividend[1] = WIDTH'(d1s[n1]);
                    bus.req_divisor[1]  = WIDTH'(v1s[n1]);
                end else bus.req_valid[1] = 1'b0;
            end
        end
        bus.req_valid = '0;
        for (int t = 0; t < 50 && sb.size() != 0; t++) @(posedge clk);
        #1;
        chk("fair_grants", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++) chk("fair_order", grant_log[i], i % 2);
        chk("fair_rsps", rsp_log.size(), 6);
        if (rsp_log.size() >= 2) begin
            chk("simul_first_id", rsp_log[0].id, 0);
            chk("simul_first_q", rsp_log[0].q, 3);
            chk("simul_first_r", rsp_log[0].r, 3);
            chk("simul_second_id", rsp_log[1].id, 1);
            chk("simul_second_q", rsp_log[1].q, 2);
            chk("simul_second_r", rsp_log[1].r, 2);
        end

        // Backpressure: result 7/2 held for several cycles with req1 waiting.
        bus.rsp_ready = 1'b0;
        issue(0, 7, 2);
        wait_rsp(lat);
        chk("bp_latency", lat, 4);
        @(posedge clk);
        #1;
        bus.req_dividend[1] = 4'd6;
        bus.req_divisor[1]  = 4'd3;
        bus.req_valid[1]    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_valid", int'(bus.rsp_valid), 1);
            chk("bp_id", int'(bus.rsp_id), 0);
            chk("bp_quot", int'(bus.rsp_quotient), 3);
            chk("bp_rem", int'(bus.rsp_remainder), 1);
            chk("bp_req_ready", int'(bus.req_ready), 0);
            @(posedge clk);
            #1;
        end
        bus.rsp_ready = 1'b1;
        issue(1, 6, 3);
        wait_rsp(lat);
        chk("bp_after_latency", lat, 4);
        chk("bp_after_id", int'(bus.rsp_id), 1);
        chk("bp_after_quot", int'(bus.rsp_quotient), 2);
        @(posedge clk);
        #1;

        // Reset during the second CALC step.
        issue(0, 13, 3);
        @(posedge clk);
        #2;
        bus.req_valid[0] = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.req_valid = '0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        chk("midrst_no_rsp", int'(seen), 0);
        @(posedge clk);
        #1;
        issue(0, 9, 3);
        wait_rsp(lat);
        chk("midrst_next_latency", lat, 4);
        chk("midrst_next_quot", int'(bus.rsp_quotient), 3);
        chk("midrst_next_rem", int'(bus.rsp_remainder), 0);
        @(posedge clk);
        #1;

        // Exhaustive operand sweep, alternating requesters.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue((a * 16 + b) % 2, a, b);
                wait_rsp(lat);
                chk("sweep_latency", lat, (b == 0) ? 1 : 4);
                @(posedge clk);
                #1;
            end
        end

        repeat (2) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end
endmodule
